layer_tile_scheduler: RTL and testbench

- Sequences one CNN layer over the systolic array once Control_Unit pulses start_layer.
- Splits the layer into tiles of up to PE_FILTERS filters × PE_CHANNELS input channels. Loop order: filter group outer, channel group inner.
- Issues one tile_start per tile and waits for the array's tile_done. Pulses done_layer after the last tile; this output drives Control_Unit's done_layer input.

---
 rtl/layer_tile_scheduler_if.sv | 36 +++
 rtl/layer_tile_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_layer_tile_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/layer_tile_scheduler_if.sv
// Purpose: groups the layer-config, tile-handshake and tile-descriptor signals of layer_tile_scheduler.
// Latency: none; wires only.
// Flow control: tile_start/tile_done pulse handshake, one tile in flight at a time.
// Ports (master = scheduler side):
//   in : start_layer, ifm_channel[10:0], num_filter[10:0], kernel_size[1:0], tile_done
//   out: tile_start, filter_base[10:0], filter_cnt[4:0], chan_base[10:0], chan_cnt[4:0],
//        first_chan, last_chan, busy, done_layer, cfg_err
interface layer_tile_scheduler_if;
  logic        start_layer;
  logic [10:0] ifm_channel;
  logic [10:0] num_filter;
  logic [1:0]  kernel_size;
  logic        tile_done;
  logic        tile_start;
  logic [10:0] filter_base;
  logic [4:0]  filter_cnt;
  logic [10:0] chan_base;
  logic [4:0]  chan_cnt;
  logic        first_chan;
  logic        last_chan;
  logic        busy;
  logic        done_layer;
  logic        cfg_err;

  modport master (
    input  start_layer, ifm_channel, num_filter, kernel_size, tile_done,
    output tile_start, filter_base, filter_cnt, chan_base, chan_cnt,
           first_chan, last_chan, busy, done_layer, cfg_err
  );

  modport slave (
    output start_layer, ifm_channel, num_filter, kernel_size, tile_done,
    input  tile_start, filter_base, filter_cnt, chan_base, chan_cnt,
           first_chan, last_chan, busy, done_layer, cfg_err
  );
endinterface

// File: rtl/layer_tile_scheduler.sv
// Purpose: walks one CNN layer as filter-group (outer) x channel-group (inner) tiles for the systolic array.
// Latency: start_layer -> first tile_start 2 cycles; tile_done -> next tile_start or done_layer 1 cycle.
// Flow control: one tile outstanding; waits for tile_done; start_layer ignored unless idle (no queueing).
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   sched (master)    : layer config + start_layer in, tile_done in; tile descriptor,
//                       tile_start, busy, done_layer, cfg_err out
module layer_tile_scheduler #(
  parameter int PE_FILTERS  = 16,
  parameter int PE_CHANNELS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  layer_tile_scheduler_if.master sched
);

  localparam int FB = $clog2(PE_FILTERS);
  localparam int CB = $clog2(PE_CHANNELS);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;

  state_t      state_q, state_d;

  // latched layer configuration
  logic [10:0] cfg_ic, cfg_nf;
  logic [1:0]  cfg_ks;
  logic        err_q, err_d;

  // tile-group counters and last-group indices (NF-1, NC-1)
  logic [6:0]  fg_q, fg_d, cg_q, cg_d;
  logic [6:0]  nf_last_q, nc_last_q;

  // registered tile descriptor
  logic [10:0] filter_base_q, chan_base_q;
  logic [4:0]  filter_cnt_q, chan_cnt_q;
  logic        first_chan_q, last_chan_q;

  logic        load_cfg, load_cnt, load_desc, clr_desc;
  logic        cfg_bad;

  // Tile counts via shift plus nonzero-remainder. One extra bit so that
  // 2033..2047 (ceil = 128) does not wrap before the -1.
  logic [7:0]  nf_tiles, nc_tiles;
  logic [6:0]  nf_last_c, nc_last_c, nc_last_sel;

  assign nf_tiles  = 8'(cfg_nf >> FB) + 8'(|cfg_nf[FB-1:0]);
  assign nc_tiles  = 8'(cfg_ic >> CB) + 8'(|cfg_ic[CB-1:0]);
  assign nf_last_c = 7'(nf_tiles - 8'd1);
  assign nc_last_c = 7'(nc_tiles - 8'd1);
  assign cfg_bad   = (cfg_ic == 11'd0) || (cfg_nf == 11'd0) ||
                     ((cfg_ks != 2'd1) && (cfg_ks != 2'd3));

  // The first descriptor is built in LOAD, before nc_last_q is written.
  assign nc_last_sel = (state_q == LOAD) ? nc_last_c : nc_last_q;

  // Next-state and control
  always_comb begin
    state_d   = state_q;
    fg_d      = fg_q;
    cg_d      = cg_q;
    err_d     = err_q;
    load_cfg  = 1'b0;
    load_cnt  = 1'b0;
    load_desc = 1'b0;
    clr_desc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sched.start_layer) begin
          load_cfg = 1'b1;
          err_d    = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        fg_d     = 7'd0;
        cg_d     = 7'd0;
        load_cnt = 1'b1;
        if (cfg_bad) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          load_desc = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (sched.tile_done) begin
          if (cg_q != nc_last_q) begin
            cg_d      = 7'(cg_q + 7'd1);
            load_desc = 1'b1;
            state_d   = ISSUE;
          end else if (fg_q != nf_last_q) begin
            cg_d      = 7'd0;
            fg_d      = 7'(fg_q + 7'd1);
            load_desc = 1'b1;
            state_d   = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        clr_desc = 1'b1;
        err_d    = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Descriptor for the tile being entered (indexed by the next counters).
  logic [10:0] fbase_d, cbase_d, frem, crem;
  logic [4:0]  fcnt_d, ccnt_d;

  assign fbase_d = 11'(fg_d) << FB;
  assign cbase_d = 11'(cg_d) << CB;
  assign frem    = cfg_nf - fbase_d;
  assign crem    = cfg_ic - cbase_d;
  assign fcnt_d  = (frem >= 11'(PE_FILTERS))  ? 5'(PE_FILTERS)  : frem[4:0];
  assign ccnt_d  = (crem >= 11'(PE_CHANNELS)) ? 5'(PE_CHANNELS) : crem[4:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ic    <= '0;
      cfg_nf    <= '0;
      cfg_ks    <= '0;
      err_q     <= 1'b0;
      fg_q      <= '0;
      cg_q      <= '0;
      nf_last_q <= '0;
      nc_last_q <= '0;
    end else begin
      err_q <= err_d;
      fg_q  <= fg_d;
      cg_q  <= cg_d;
      if (load_cfg) begin
        cfg_ic <= sched.ifm_channel;
        cfg_nf <= sched.num_filter;
        cfg_ks <= sched.kernel_size;
      end
      if (load_cnt) begin
        nf_last_q <= nf_last_c;
        nc_last_q <= nc_last_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filter_base_q <= '0;
      filter_cnt_q  <= '0;
      chan_base_q   <= '0;
      chan_cnt_q    <= '0;
      first_chan_q  <= 1'b0;
      last_chan_q   <= 1'b0;
    end else if (clr_desc) begin
      filter_base_q <= '0;
      filter_cnt_q  <= '0;
      chan_base_q   <= '0;
      chan_cnt_q    <= '0;
      first_chan_q  <= 1'b0;
      last_chan_q   <= 1'b0;
    end else if (load_desc) begin
      filter_base_q <= fbase_d;
      filter_cnt_q  <= fcnt_d;
      chan_base_q   <= cbase_d;
      chan_cnt_q    <= ccnt_d;
      first_chan_q  <= (cg_d == 7'd0);
      last_chan_q   <= (cg_d == nc_last_sel);
    end
  end

  assign sched.tile_start  = (state_q == ISSUE);
  assign sched.busy        = (state_q != IDLE);
  assign sched.done_layer  = (state_q == DONE);
  assign sched.cfg_err     = (state_q == DONE) && err_q;
  assign sched.filter_base = filter_base_q;
  assign sched.filter_cnt  = filter_cnt_q;
  assign sched.chan_base   = chan_base_q;
  assign sched.chan_cnt    = chan_cnt_q;
  assign sched.first_chan  = first_chan_q;
  assign sched.last_chan   = last_chan_q;

endmodule

// File: tb/tb_layer_tile_scheduler.sv
// Purpose: randomized self-checking bench for layer_tile_scheduler against a loop-nest tile model.
// Latency: checks start->tile_start 2, tile_done->next tile_start/done_layer 1, done->idle 1.
// Flow control: bench plays the array, answering each tile_start with tile_done after a random delay.
module tb_layer_tile_scheduler;
  localparam int PF = 16;
  localparam int PC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  layer_tile_scheduler_if bus();

  layer_tile_scheduler #(.PE_FILTERS(PF), .PE_CHANNELS(PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sched (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [33:0] pack(input int fb, input int fc, input int cb, input int cc,
                                       input bit fi, input bit la);
    return {11'(fb), 5'(fc), 11'(cb), 5'(cc), fi, la};
  endfunction

  function automatic logic [33:0] desc_now();
    return {bus.filter_base, bus.filter_cnt, bus.chan_base, bus.chan_cnt,
            bus.first_chan, bus.last_chan};
  endfunction

  task automatic scramble_cfg();
    bus.ifm_channel = 11'($urandom);
    bus.num_filter  = 11'($urandom);
    bus.kernel_size = 2'($urandom);
  endtask

  // Runs one layer. Caller is at a sample point (#1 after a rising edge) with the DUT idle.
  task automatic run_layer(input int ic, input int nf, input int ks, input int dmin, input int dmax,
                           input bit dup, input bit spur, input int rst_tile);
    logic [33:0] q[$];
    int  first_exp = 0, first_obs = 0, n_tiles = 0, total;
    int  start_cyc, exp_ts, exp_done, done_at, ts_cyc, limit;
    bit  exp_err, finished;

    exp_err = (ic == 0) || (nf == 0) || !(ks == 1 || ks == 3);
    if (!exp_err)
      for (int f = 0; f < nf; f += PF)
        for (int c = 0; c < ic; c += PC) begin
          q.push_back(pack(f, min_i(PF, nf - f), c, min_i(PC, ic - c), c == 0, c + PC >= ic));
          if (c == 0) first_exp++;
        end
    total = q.size();

    bus.ifm_channel = 11'(ic);
    bus.num_filter  = 11'(nf);
    bus.kernel_size = 2'(ks);
    bus.start_layer = 1'b1;
    bus.tile_done   = spur;          // coincident with start in IDLE: must be ignored
    start_cyc = cyc;
    exp_ts    = exp_err ? -1 : start_cyc + 2;
    exp_done  = exp_err ? start_cyc + 2 : -1;
    done_at   = -1;
    ts_cyc    = -10;
    limit     = start_cyc + 20 + total * (dmax + 4);
    finished  = 1'b0;

    while (!finished) begin
      @(posedge clk); #1;
      bus.start_layer = 1'b0;
      bus.tile_done   = 1'b0;

      if (cyc == start_cyc + 1) begin
        chk_eq("busy_load", bus.busy, 1);
        scramble_cfg();              // latched config must not follow the pins
      end

      if (bus.tile_start || cyc == exp_ts)
        chk_eq("tile_start", bus.tile_start, cyc == exp_ts);
      if (bus.tile_start) begin
        n_tiles++;
        ts_cyc = cyc;
        exp_ts = -1;
        if (bus.first_chan) first_obs++;
        if (q.size() == 0) chk_eq("extra_tile", bus.tile_start, 0);
        else               chk_eq("desc", desc_now(), q.pop_front());
        done_at = cyc + $urandom_range(dmax, dmin);
        if (spur) bus.tile_done = 1'b1;   // lands in ISSUE: must be ignored
      end

      if (rst_tile >= 0 && n_tiles == rst_tile + 1 && cyc == ts_cyc + 1) begin
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_busy", bus.busy, 0);
        chk_eq("rst_desc", desc_now(), 0);
        chk_eq("rst_pulses", {bus.tile_start, bus.done_layer, bus.cfg_err}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(posedge clk); #1;
          chk_eq("rst_quiet", {bus.done_layer, bus.busy, bus.tile_start}, 0);
        end
        return;
      end

      if (dup && cyc == ts_cyc + 1) begin
        bus.start_layer = 1'b1;      // in WAIT: must be ignored
        scramble_cfg();
      end

      if (cyc == done_at) begin
        bus.tile_done = 1'b1;
        done_at = -1;
        if (q.size() == 0) exp_done = cyc + 1;
        else               exp_ts   = cyc + 1;
      end

      if (bus.done_layer || cyc == exp_done) begin
        chk_eq("done_layer", bus.done_layer, cyc == exp_done);
        if (cyc == exp_done) begin
          chk_eq("cfg_err", bus.cfg_err, exp_err);
          chk_eq("busy_done", bus.busy, 1);
          chk_eq("tile_count", n_tiles, total);
          chk_eq("first_cnt", first_obs, first_exp);
          if (exp_err) chk_eq("err_desc", desc_now(), 0);
          finished = 1'b1;
        end
      end else if (bus.cfg_err) begin
        chk_eq("cfg_err_stray", bus.cfg_err, 0);
      end

      if (!finished && cyc > limit) begin
        chk_eq("timeout", finished, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
    end

    @(posedge clk); #1;
    chk_eq("idle_busy", bus.busy, 0);
    chk_eq("idle_desc", desc_now(), 0);
    chk_eq("idle_pulses", {bus.done_layer, bus.tile_start, bus.cfg_err}, 0);
  endtask

  initial begin
    int ic, nf, ks;
    bus.start_layer = 1'b0;
    bus.tile_done   = 1'b0;
    bus.ifm_channel = '0;
    bus.num_filter  = '0;
    bus.kernel_size = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("reset_desc", desc_now(), 0);
    chk_eq("reset_flags", {bus.tile_start, bus.busy, bus.done_layer, bus.cfg_err}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_layer(3,   16,  3, 5, 5, 0, 0, -1);   // single tile
    run_layer(512, 255, 1, 1, 3, 0, 0, -1);   // 512 tiles, partial last filter group
    run_layer(384, 256, 3, 1, 1, 0, 0, -1);   // back-to-back tiles
    run_layer(16,  16,  2, 1, 1, 0, 0, -1);   // illegal kernel
    run_layer(16,  0,   3, 1, 1, 0, 0, -1);   // no filters
    run_layer(0,   16,  1, 1, 1, 0, 0, -1);   // no channels
    run_layer(40,  33,  3, 1, 4, 1, 1, -1);   // ignored start and tile_done
    run_layer(64,  48,  1, 2, 4, 0, 0, 5);    // reset mid-WAIT
    run_layer(64,  48,  1, 1, 3, 0, 0, -1);   // full rerun after reset
    run_layer(20,  2047, 3, 1, 1, 0, 0, -1);  // 128 filter groups
    run_layer(2047, 17, 1, 1, 1, 0, 0, -1);   // 128 channel groups

    for (int i = 0; i < 10; i++) begin
      ic = $urandom_range(100, 1);
      nf = $urandom_range(100, 1);
      ks = ($urandom_range(9, 0) == 0) ? 2 : (($urandom_range(1, 0) == 1) ? 1 : 3);
      run_layer(ic, nf, ks, 1, 4, 1'($urandom), 1'($urandom), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
